// File: rtl/toy_pack.sv
// Shared LSU types: memory-ack payload and writeback-arbiter source IDs.
package toy_pack;

   localparam int unsigned MEM_DATA_W = 32;
   localparam int unsigned MEM_SB_W   = 12;

   typedef struct packed {
      logic [MEM_DATA_W-1:0] data;
      logic [MEM_SB_W-1:0]   sideband;
   } mem_ack_pkg;

   localparam int unsigned LSU_WB_NUM_REQ = 3;
   localparam int unsigned LSU_WB_SRC_LD  = 0;
   localparam int unsigned LSU_WB_SRC_UC  = 1;
   localparam int unsigned LSU_WB_SRC_SB  = 2;

endpackage

// File: rtl/toy_rr_arb.sv
// N-way round-robin picker: first set request at or after ptr (modulo N) wins.
module toy_rr_arb #(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_c,
   output logic [IW-1:0] idx_c,
   output logic          vld_c
);

   always_comb begin
      int unsigned j;
      logic [IW-1:0] cand;
      gnt_c = '0;
      idx_c = '0;
      vld_c = 1'b0;
      j     = 0;
      cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(ptr) + k;
         if (j >= N) j = j - N;
         cand = IW'(j);
         if (!vld_c && req[cand]) begin
            vld_c       = 1'b1;
            gnt_c[cand] = 1'b1;
            idx_c       = cand;
         end
      end
   end

endmodule

// File: rtl/toy_lsu_wb_arb.sv
// Shares the LSU writeback port among NUM_REQ ack sources via 1-entry buffers and RR arbitration.
// Define TOY_LSU_WB_ARB_PRIO_EN to give source 0 (load pipe) fixed highest priority.
module toy_lsu_wb_arb
   import toy_pack::*;
#(
   parameter int unsigned NUM_REQ  = LSU_WB_NUM_REQ,
   parameter int unsigned REQ_ID_W = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            cancel_en,
   input  logic       [NUM_REQ-1:0]        req_vld,
   input  mem_ack_pkg [NUM_REQ-1:0]        req_pld,
   output logic       [NUM_REQ-1:0]        req_rdy,
   output logic                            wb_vld,
   output mem_ack_pkg                      wb_pld,
   output logic       [REQ_ID_W-1:0]       wb_src
);

   logic       [NUM_REQ-1:0]  buf_vld;
   mem_ack_pkg [NUM_REQ-1:0]  buf_pld;
   logic       [REQ_ID_W-1:0] rr_ptr;

   logic       [NUM_REQ-1:0]  arb_req;
   logic       [NUM_REQ-1:0]  rr_gnt;
   logic       [REQ_ID_W-1:0] rr_idx;
   logic                      rr_vld;

   logic       [NUM_REQ-1:0]  grant;
   logic       [REQ_ID_W-1:0] win_idx;
   logic                      any_grant;
   logic                      ptr_upd;
   logic       [NUM_REQ-1:0]  accept;

   toy_rr_arb #(
      .N  (NUM_REQ),
      .IW (REQ_ID_W)
   ) u_rr_arb (
      .req   (arb_req),
      .ptr   (rr_ptr),
      .gnt_c (rr_gnt),
      .idx_c (rr_idx),
      .vld_c (rr_vld)
   );

`ifdef TOY_LSU_WB_ARB_PRIO_EN
   // Source 0 bypasses the rotation; the pointer only tracks sources 1..NUM_REQ-1.
   assign arb_req = buf_vld & ~NUM_REQ'(1);

   always_comb begin
      grant     = rr_gnt;
      win_idx   = rr_idx;
      any_grant = rr_vld;
      ptr_upd   = rr_vld & ~cancel_en;
      if (buf_vld[0]) begin
         grant     = NUM_REQ'(1);
         win_idx   = '0;
         any_grant = 1'b1;
         ptr_upd   = 1'b0;
      end
   end
`else
   assign arb_req = buf_vld;

   always_comb begin
      grant     = rr_gnt;
      win_idx   = rr_idx;
      any_grant = rr_vld;
      ptr_upd   = rr_vld & ~cancel_en;
   end
`endif

   // A granted buffer frees its slot in the same cycle, allowing back-to-back refill.
   assign req_rdy = {NUM_REQ{~cancel_en}} & (~buf_vld | grant);
   assign accept  = req_vld & req_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_vld <= '0;
         wb_vld  <= 1'b0;
         wb_src  <= '0;
         rr_ptr  <= '0;
      end else begin
         if (cancel_en) begin
            buf_vld <= '0;
         end else begin
            buf_vld <= (buf_vld & ~grant) | accept;
         end
         wb_vld <= (|buf_vld) & ~cancel_en;
         if (any_grant) begin
            wb_src <= win_idx;
         end
         if (ptr_upd) begin
            rr_ptr <= (win_idx == REQ_ID_W'(NUM_REQ - 1)) ? '0 : win_idx + REQ_ID_W'(1);
         end
      end
   end

   // Payload storage carries no reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (accept[i]) begin
            buf_pld[i] <= req_pld[i];
         end
      end
      if (any_grant) begin
         wb_pld <= buf_pld[win_idx];
      end
   end

endmodule

// File: tb/tb_toy_lsu_wb_arb.sv
// Directed self-checking bench for toy_lsu_wb_arb (3 sources).
module tb_toy_lsu_wb_arb;
   import toy_pack::*;

   localparam int unsigned N  = LSU_WB_NUM_REQ;
   localparam int unsigned IW = $clog2(N);

   logic                 clk;
   logic                 rst_n;
   logic                 cancel_en;
   logic       [N-1:0]   req_vld;
   mem_ack_pkg [N-1:0]   req_pld;
   logic       [N-1:0]   req_rdy;
   logic                 wb_vld;
   mem_ack_pkg           wb_pld;
   logic       [IW-1:0]  wb_src;

   int checks;
   int failures;

   toy_lsu_wb_arb #(
      .NUM_REQ  (N),
      .REQ_ID_W (IW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cancel_en (cancel_en),
      .req_vld   (req_vld),
      .req_pld   (req_pld),
      .req_rdy   (req_rdy),
      .wb_vld    (wb_vld),
      .wb_pld    (wb_pld),
      .wb_src    (wb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pld();
      req_pld[0] = '{data: 32'hAAAA_0000, sideband: 12'h0A0};
      req_pld[1] = '{data: 32'hBBBB_0001, sideband: 12'h1B1};
      req_pld[2] = '{data: 32'hCCCC_0002, sideband: 12'h2C2};
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      cancel_en = 1'b0;
      req_vld   = '0;
      set_pld();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      cancel_en = 1'b0;
      req_vld   = '0;
      set_pld();
      #3;
      checks++;
      if (wb_vld !== 1'b0) begin
         failures++; $display("FAIL reset_wb_vld: got %b exp 0", wb_vld);
      end
      checks++;
      if (wb_src !== 2'd0) begin
         failures++; $display("FAIL reset_wb_src: got %0d exp 0", wb_src);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_rdy !== 3'b111) begin
         failures++; $display("FAIL reset_req_rdy: got %b exp 111", req_rdy);
      end
   endtask

   task automatic test_single();
      do_reset();
      tick();
      req_pld[1] = '{data: 32'h1234_5678, sideband: 12'h1A5};
      req_vld    = 3'b010;
      #1;
      checks++;
      if (req_rdy[1] !== 1'b1) begin
         failures++; $display("FAIL single_rdy_accept: got %b exp 1", req_rdy[1]);
      end
      tick();
      req_vld = '0;
      #1;
      checks++;
      if (wb_vld !== 1'b0) begin
         failures++; $display("FAIL single_wb_early: got %b exp 0", wb_vld);
      end
      checks++;
      if (req_rdy[1] !== 1'b1) begin
         failures++; $display("FAIL single_rdy_held: got %b exp 1", req_rdy[1]);
      end
      tick();
      checks++;
      if (wb_vld !== 1'b1 || wb_src !== 2'd1) begin
         failures++; $display("FAIL single_wb: got vld=%b src=%0d exp vld=1 src=1", wb_vld, wb_src);
      end
      checks++;
      if (wb_pld.sideband !== 12'h1A5 || wb_pld.data !== 32'h1234_5678) begin
         failures++; $display("FAIL single_pld: got %h/%h exp 1a5/12345678", wb_pld.sideband, wb_pld.data);
      end
      tick();
      checks++;
      if (wb_vld !== 1'b0 || wb_src !== 2'd1) begin
         failures++; $display("FAIL single_idle: got vld=%b src=%0d exp vld=0 src=1", wb_vld, wb_src);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0]  exp_rdy;
      logic [IW-1:0] exp_src;
      logic [11:0]   exp_sb [N];
      exp_sb[0] = 12'h0A0;
      exp_sb[1] = 12'h1B1;
      exp_sb[2] = 12'h2C2;
      do_reset();
      tick();
      req_vld = 3'b111;
      tick();
      for (int k = 0; k < 9; k++) begin
         exp_rdy = 3'b001 << (k % 3);
         exp_src = IW'(k % 3);
         checks++;
         if (req_rdy !== exp_rdy) begin
            failures++; $display("FAIL rr_rdy[%0d]: got %b exp %b", k, req_rdy, exp_rdy);
         end
         tick();
         checks++;
         if (wb_vld !== 1'b1 || wb_src !== exp_src || wb_pld.sideband !== exp_sb[k % 3]) begin
            failures++;
            $display("FAIL rr_wb[%0d]: got vld=%b src=%0d sb=%h exp vld=1 src=%0d sb=%h",
                     k, wb_vld, wb_src, wb_pld.sideband, exp_src, exp_sb[k % 3]);
         end
      end
      req_vld = '0;
      repeat (4) tick();
   endtask

   task automatic test_contention();
      do_reset();
      tick();
      req_pld[0] = '{data: 32'h0000_0A00, sideband: 12'h0A0};
      req_pld[2] = '{data: 32'h0000_2A20, sideband: 12'h2A2};
      req_vld    = 3'b101;
      #1;
      checks++;
      if (req_rdy !== 3'b111) begin
         failures++; $display("FAIL cont_rdy_pre: got %b exp 111", req_rdy);
      end
      tick();
      req_pld[2] = '{data: 32'h0000_2FF0, sideband: 12'h2FF};
      req_vld    = 3'b100;
      #1;
      checks++;
      if (req_rdy !== 3'b011) begin
         failures++; $display("FAIL cont_rdy_wait: got %b exp 011", req_rdy);
      end
      tick();
      req_vld = '0;
      #1;
      checks++;
      if (wb_vld !== 1'b1 || wb_src !== 2'd0 || wb_pld.sideband !== 12'h0A0) begin
         failures++; $display("FAIL cont_first: got vld=%b src=%0d sb=%h exp 1/0/0a0", wb_vld, wb_src, wb_pld.sideband);
      end
      tick();
      checks++;
      if (wb_vld !== 1'b1 || wb_src !== 2'd2 || wb_pld.sideband !== 12'h2A2) begin
         failures++; $display("FAIL cont_second: got vld=%b src=%0d sb=%h exp 1/2/2a2", wb_vld, wb_src, wb_pld.sideband);
      end
      tick();
      checks++;
      if (wb_vld !== 1'b0) begin
         failures++; $display("FAIL cont_drain: got vld=%b exp 0", wb_vld);
      end
   endtask

   task automatic test_cancel();
      do_reset();
      tick();
      req_vld = 3'b001;
      tick();
      req_vld = '0;
      tick();
      req_vld = 3'b111;
      tick();
      cancel_en = 1'b1;
      #1;
      checks++;
      if (req_rdy !== 3'b000) begin
         failures++; $display("FAIL cancel_rdy: got %b exp 000", req_rdy);
      end
      tick();
      cancel_en = 1'b0;
      req_vld   = '0;
      #1;
      checks++;
      if (wb_vld !== 1'b0) begin
         failures++; $display("FAIL cancel_wb: got %b exp 0", wb_vld);
      end
      checks++;
      if (req_rdy !== 3'b111) begin
         failures++; $display("FAIL cancel_rdy_after: got %b exp 111", req_rdy);
      end
      tick();
      checks++;
      if (wb_vld !== 1'b0) begin
         failures++; $display("FAIL cancel_buf_cleared: got %b exp 0", wb_vld);
      end
      req_vld = 3'b111;
      tick();
      req_vld = '0;
      tick();
      checks++;
      if (wb_vld !== 1'b1 || wb_src !== 2'd1) begin
         failures++; $display("FAIL cancel_ptr_hold: got vld=%b src=%0d exp 1/1", wb_vld, wb_src);
      end
      repeat (3) tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      tick();
      req_vld = 3'b001;
      tick();
      req_vld = '0;
      tick();
      checks++;
      if (wb_vld !== 1'b1) begin
         failures++; $display("FAIL areset_pre: got %b exp 1", wb_vld);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (wb_vld !== 1'b0) begin
         failures++; $display("FAIL areset_async: got %b exp 0", wb_vld);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      req_vld = 3'b111;
      tick();
      req_vld = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (wb_vld !== 1'b1 || wb_src !== IW'(k)) begin
            failures++; $display("FAIL areset_ptr[%0d]: got vld=%b src=%0d exp 1/%0d", k, wb_vld, wb_src, k);
         end
      end
      tick();
   endtask

`ifdef TOY_LSU_WB_ARB_PRIO_EN
   task automatic test_prio();
      do_reset();
      tick();
      req_vld = 3'b011;
      tick();
      checks++;
      if (req_rdy !== 3'b101) begin
         failures++; $display("FAIL prio_rdy: got %b exp 101", req_rdy);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (wb_vld !== 1'b1 || wb_src !== 2'd0) begin
            failures++; $display("FAIL prio_src0[%0d]: got vld=%b src=%0d exp 1/0", k, wb_vld, wb_src);
         end
      end
      req_vld = '0;
      tick();
      checks++;
      if (wb_vld !== 1'b1 || wb_src !== 2'd0) begin
         failures++; $display("FAIL prio_last0: got vld=%b src=%0d exp 1/0", wb_vld, wb_src);
      end
      tick();
      checks++;
      if (wb_vld !== 1'b1 || wb_src !== 2'd1) begin
         failures++; $display("FAIL prio_src1: got vld=%b src=%0d exp 1/1", wb_vld, wb_src);
      end
      tick();
   endtask
`endif

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      cancel_en = 1'b0;
      req_vld   = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_contention();
      test_cancel();
      test_async_reset();
`ifdef TOY_LSU_WB_ARB_PRIO_EN
      test_prio();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
